// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between an instruction-fetch
// port and a load/store data port, with one-cycle read-data return and a conflict counter.
module mem_port_arbiter #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [15:0]   conflict_cnt
);

   typedef enum logic {OWN_IF, OWN_D} owner_e;

   owner_e        last_q, last_d;
   logic          if_pend_q, if_pend_d;
   logic          d_pend_q, d_pend_d;
   logic [DW-1:0] if_hold_q, d_hold_q;
   logic [15:0]   cnt_q, cnt_d;

   always_comb begin
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      last_d    = last_q;
      // Grants are masked while rst is high so nothing starts before reset releases.
      if (!rst) begin
         if (if_req && d_req) begin
            if (last_q == OWN_IF) d_gnt  = 1'b1;
            else                  if_gnt = 1'b1;
         end else begin
            if_gnt = if_req;
            d_gnt  = d_req;
         end
      end
      if (d_gnt) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         last_d    = OWN_D;
      end else if (if_gnt) begin
         mem_en    = 1'b1;
         mem_addr  = if_addr;
         last_d    = OWN_IF;
      end
      if_pend_d = if_gnt;
      d_pend_d  = d_gnt && !d_we;
      cnt_d     = cnt_q;
      if (if_req && d_req && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q    <= OWN_IF;
         if_pend_q <= 1'b0;
         d_pend_q  <= 1'b0;
         if_hold_q <= '0;
         d_hold_q  <= '0;
         cnt_q     <= '0;
      end else begin
         last_q    <= last_d;
         if_pend_q <= if_pend_d;
         d_pend_q  <= d_pend_d;
         if (if_pend_q) if_hold_q <= mem_rdata;
         if (d_pend_q)  d_hold_q  <= mem_rdata;
         cnt_q     <= cnt_d;
      end
   end

   // Read data passes straight through in its valid cycle and is latched for later holding.
   assign if_rvalid    = if_pend_q;
   assign d_rvalid     = d_pend_q;
   assign if_rdata     = if_pend_q ? mem_rdata : if_hold_q;
   assign d_rdata      = d_pend_q  ? mem_rdata : d_hold_q;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small behavioural
// single-port memory returning read data one cycle after an enabled read.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we;
   logic [9:0]  if_addr, d_addr;
   logic [31:0] d_wdata;
   logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
   logic [31:0] if_rdata, d_rdata;
   logic        mem_en, mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic [15:0] conflict_cnt;

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [31:0] mem [1024];

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(10), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .conflict_cnt(conflict_cnt)
   );

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[4]    = 32'h00500093;
      mem[16]   = 32'h11112222;
      mem_rdata = 32'h0;
      rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;

      // Requests during reset are ignored and the counter stays cleared
      repeat (2) @(negedge clk);
      if_req = 1'b1; d_req = 1'b1;
      #1;
      chk("rst_if_gnt", 32'(if_gnt), 32'd0);
      chk("rst_d_gnt", 32'(d_gnt), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      @(negedge clk); #1;
      chk("rst_cnt", 32'(conflict_cnt), 32'd0);
      @(negedge clk);
      if_req = 1'b0; d_req = 1'b0; rst = 1'b0;
      #1;
      chk("idle_mem_en", 32'(mem_en), 32'd0);
      chk("idle_mem_addr", 32'(mem_addr), 32'd0);

      // Fetch only
      @(negedge clk);
      if_req = 1'b1; if_addr = 10'h004;
      #1;
      chk("f_if_gnt", 32'(if_gnt), 32'd1);
      chk("f_d_gnt", 32'(d_gnt), 32'd0);
      chk("f_mem_en", 32'(mem_en), 32'd1);
      chk("f_mem_addr", 32'(mem_addr), 32'h004);
      chk("f_mem_we", 32'(mem_we), 32'd0);
      chk("f_mem_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      if_req = 1'b0;
      #1;
      chk("f_if_rvalid", 32'(if_rvalid), 32'd1);
      chk("f_if_rdata", if_rdata, 32'h00500093);
      chk("f_d_gnt2", 32'(d_gnt), 32'd0);
      chk("f_d_rvalid", 32'(d_rvalid), 32'd0);
      @(negedge clk); #1;
      chk("f_rvalid_drop", 32'(if_rvalid), 32'd0);
      chk("f_rdata_hold", if_rdata, 32'h00500093);

      // Conflict: last owner is fetch, so data wins first
      @(negedge clk);
      if_req = 1'b1; if_addr = 10'h004; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
      #1;
      chk("c1_d_gnt", 32'(d_gnt), 32'd1);
      chk("c1_if_gnt", 32'(if_gnt), 32'd0);
      chk("c1_mem_addr", 32'(mem_addr), 32'h010);
      @(negedge clk);
      d_req = 1'b0;
      #1;
      chk("c2_if_gnt", 32'(if_gnt), 32'd1);
      chk("c2_d_rvalid", 32'(d_rvalid), 32'd1);
      chk("c2_d_rdata", d_rdata, 32'h11112222);
      chk("c2_cnt", 32'(conflict_cnt), 32'd1);
      @(negedge clk);
      if_req = 1'b0;
      #1;
      chk("c3_if_rvalid", 32'(if_rvalid), 32'd1);
      chk("c3_if_rdata", if_rdata, 32'h00500093);
      chk("c3_d_rvalid", 32'(d_rvalid), 32'd0);
      chk("c3_cnt", 32'(conflict_cnt), 32'd1);

      // Store to top word
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 10'h3FF; d_wdata = 32'hDEADBEEF;
      #1;
      chk("s_d_gnt", 32'(d_gnt), 32'd1);
      chk("s_mem_en", 32'(mem_en), 32'd1);
      chk("s_mem_we", 32'(mem_we), 32'd1);
      chk("s_mem_addr", 32'(mem_addr), 32'h3FF);
      chk("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
      @(negedge clk);
      d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
      #1;
      chk("s_d_rvalid", 32'(d_rvalid), 32'd0);
      chk("s_d_rdata_hold", d_rdata, 32'h11112222);
      chk("s_mem_we_off", 32'(mem_we), 32'd0);
      // Read back the stored word through the fetch port
      @(negedge clk);
      if_req = 1'b1; if_addr = 10'h3FF;
      @(negedge clk);
      if_req = 1'b0;
      #1;
      chk("s_readback", if_rdata, 32'hDEADBEEF);

      // Reset pulsed between a read grant and its data cycle
      @(negedge clk);
      if_req = 1'b1; if_addr = 10'h004;
      #1;
      chk("r_if_gnt", 32'(if_gnt), 32'd1);
      @(posedge clk);
      #2 rst = 1'b1; if_req = 1'b0;
      #1;
      chk("r_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("r_if_rdata", if_rdata, 32'd0);
      chk("r_d_rdata", d_rdata, 32'd0);
      chk("r_cnt", 32'(conflict_cnt), 32'd0);
      chk("r_mem_en", 32'(mem_en), 32'd0);
      #1 rst = 1'b0;
      @(negedge clk); #1;
      chk("r_after_rvalid", 32'(if_rvalid), 32'd0);

      // Sustained conflict: data wins even cycles, fetch odd; counter saturates
      @(negedge clk);
      if_req = 1'b1; d_req = 1'b1; if_addr = 10'h004; d_addr = 10'h010;
      for (int k = 0; k < 70000; k++) begin
         #1;
         chk("sus_d_gnt", 32'(d_gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("sus_if_gnt", 32'(if_gnt), (k % 2 == 0) ? 32'd0 : 32'd1);
         if (k > 0) chk("sus_d_rvalid", 32'(d_rvalid), (k % 2 == 1) ? 32'd1 : 32'd0);
         @(negedge clk);
      end
      if_req = 1'b0; d_req = 1'b0;
      #1;
      chk("sus_cnt_sat", 32'(conflict_cnt), 32'h0000FFFF);
      @(negedge clk); #1;
      chk("sus_cnt_hold", 32'(conflict_cnt), 32'h0000FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: AW, 10, word-address width of the shared memory (1024 words).
REQ-002 Parameter: DW, 32, data word width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: if_req  input  1  instruction-fetch read request; held with if_addr stable until granted.
REQ-006 Port: if_addr  input  AW  fetch word address.
REQ-007 Port: if_gnt  output  1  fetch request accepted this cycle.
REQ-008 Port: if_rvalid  output  1  fetch read data valid.
REQ-009 Port: if_rdata  output  DW  fetch read data.
REQ-010 Port: d_req  input  1  data-port request; held with d_we, d_addr and d_wdata stable until granted.
REQ-011 Port: d_we  input  1  1 = store, 0 = load.
REQ-012 Port: d_addr  input  AW  data word address.
REQ-013 Port: d_wdata  input  DW  store data.
REQ-014 Port: d_gnt / d_rvalid / d_rdata  output  1/1/DW  data grant, load-data valid, load data.
REQ-015 Port: mem_en / mem_we  output  1/1  shared single-port memory enable / write enable.
REQ-016 Port: mem_addr / mem_wdata  output  AW/DW  memory address / write data.
REQ-017 Port: mem_rdata  input  DW  memory read data, valid exactly one cycle after an enabled read.
REQ-018 Port: conflict_cnt  output  16  count of cycles in which both if_req and d_req were high.

Function
REQ-019 The block SHALL grant at most one requester per cycle; grants are combinational from the req inputs and the registered last_owner.
REQ-020 Single requester high: that requester SHALL be granted in the same cycle.
REQ-021 Both high: the requester that is not last_owner SHALL be granted (round-robin); the loser's gnt stays 0.
REQ-022 On every grant, last_owner SHALL update at the next edge to the granted requester; with no grant it holds.
REQ-023 In a grant cycle: mem_en=1, mem_addr = winner address; mem_we = d_we if data won, else 0; mem_wdata = d_wdata when data won, else 0.
REQ-024 With no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-025 A granted read SHALL set a registered pending-owner flag; in the next cycle the matching rvalid SHALL be 1 for exactly one cycle, and that port's rdata = mem_rdata.
REQ-026 Read latency: grant at cycle N produces rvalid at cycle N+1; back-to-back grants produce rvalid in consecutive cycles with no bubble.
REQ-027 A store (d_we=1) SHALL produce no d_rvalid.
REQ-028 rdata SHALL hold its last delivered value while its rvalid is 0.
REQ-029 conflict_cnt SHALL increment by 1 in each cycle with if_req=1 and d_req=1, and saturate at 16'hFFFF (no wrap).
REQ-030 Requests raised while rst=1 SHALL be ignored; both gnt outputs and mem_en SHALL be 0 during reset.

Reset
REQ-031 On rst assertion, asynchronously: last_owner=fetch (so the first conflict grants data), pending flags=0, if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0, conflict_cnt=0.
REQ-032 Reset asserted between a read grant and its data cycle SHALL suppress that rvalid; the read is discarded.
REQ-033 The first grant after rst deasserts SHALL occur no earlier than the first rising edge with rst=0.

Verification
REQ-034 Fetch only: if_req=1, if_addr=0x004, mem_rdata=0x00500093 the next cycle -> if_gnt=1 in cycle N, if_rvalid=1 and if_rdata=0x00500093 in N+1, d_gnt=0 throughout.
REQ-035 Conflict after reset: if_req=d_req=1, d_we=0, d_addr=0x010 -> data wins cycle 1, fetch wins cycle 2, d_rvalid in cycle 2, if_rvalid in cycle 3, conflict_cnt=1.
REQ-036 Store: d_req=1, d_we=1, d_addr=0x3FF, d_wdata=0xDEADBEEF -> mem_en=1, mem_we=1, mem_addr=0x3FF, mem_wdata=0xDEADBEEF in the grant cycle; d_rvalid stays 0.
REQ-037 Sustained conflict for 70000 cycles -> grants alternate every cycle; conflict_cnt saturates at 0xFFFF.
REQ-038 Reset mid-read: fetch granted in cycle N, rst pulsed high during cycle N+1 -> if_rvalid=0; all outputs at reset values; conflict_cnt=0.
